// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the 8-digit seven-segment scanner.
package seven_seg_pkg;

    localparam int NUM_DIGITS = 8;

    typedef logic [3:0] nibble_t;
    typedef logic [6:0] seg_t;      // {g,f,e,d,c,b,a}

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_t;

endpackage

// File: rtl/bin_to_seven_seg.sv
// Combinational hex-to-segment decoder, active-high {g,f,e,d,c,b,a}.
module bin_to_seven_seg
    import seven_seg_pkg::*;
(
    input  nibble_t bin,
    output seg_t    seg
);

    always_comb begin
        seg = 7'b0000000;
        case (bin)
            4'h0: seg = 7'b0111111;
            4'h1: seg = 7'b0000110;
            4'h2: seg = 7'b1011011;
            4'h3: seg = 7'b1001111;
            4'h4: seg = 7'b1100110;
            4'h5: seg = 7'b1101101;
            4'h6: seg = 7'b1111101;
            4'h7: seg = 7'b0000111;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1101111;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b1111100;
            4'hC: seg = 7'b0111001;
            4'hD: seg = 7'b1011110;
            4'hE: seg = 7'b1111001;
            4'hF: seg = 7'b1110001;
            default: seg = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 8-digit common-anode scanner with double-buffered
// value/enable/decimal-point registers and a per-slot blanking gap.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic [31:0] VAL,
    input  logic [7:0]  DP_IN,
    input  logic [7:0]  DIGIT_EN,
    input  logic        UPDATE,
    output logic        CA,
    output logic        CB,
    output logic        CC,
    output logic        CD,
    output logic        CE,
    output logic        CF,
    output logic        CG,
    output logic        DP,
    output logic [7:0]  AN,
    output logic        FRAME_TICK
);

    localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [2:0]       LAST_DIG  = 3'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       digit;
    scan_state_t      state, state_next;
    logic             frame_end;
    logic             frame_seen;

    logic [31:0] pend_val, active_val;
    logic [7:0]  pend_dp, active_dp;
    logic [7:0]  pend_en, active_en;
    logic        pend_valid;

    nibble_t cur_nib;
    seg_t    cur_seg;

    logic [7:0] an_next, an_p1;
    seg_t       seg_next, seg_p1;
    logic       dp_next, dp_p1;
    logic       tick_next, tick_p1;

    assign frame_end = (digit == LAST_DIG) && (cnt == LAST_CNT);

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            cnt        <= '0;
            digit      <= '0;
            state      <= BLANK;
            frame_seen <= 1'b0;
        end else begin
            state <= state_next;
            if (cnt == LAST_CNT) begin
                cnt   <= '0;
                digit <= digit + 3'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (frame_end)
                frame_seen <= 1'b1;
        end
    end

    // State mirrors the counter: ON from BLANK_CYCLES up to the slot wrap.
    always_comb begin
        state_next = state;
        case (state)
            BLANK:   if (cnt == BLANK_END) state_next = ON;
            ON:      if (cnt == LAST_CNT)  state_next = BLANK;
            default: state_next = BLANK;
        endcase
    end

    // An UPDATE landing on the transfer edge overrides the pend_valid clear,
    // so its values wait for the following frame boundary.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_en    <= '0;
            pend_valid <= 1'b0;
            active_val <= '0;
            active_dp  <= '0;
            active_en  <= '0;
        end else begin
            if (frame_end && pend_valid) begin
                active_val <= pend_val;
                active_dp  <= pend_dp;
                active_en  <= pend_en;
                pend_valid <= 1'b0;
            end
            if (UPDATE) begin
                pend_val   <= VAL;
                pend_dp    <= DP_IN;
                pend_en    <= DIGIT_EN;
                pend_valid <= 1'b1;
            end
        end
    end

    assign cur_nib = active_val[{digit, 2'b00} +: 4];

    bin_to_seven_seg u_dec (
        .bin (cur_nib),
        .seg (cur_seg)
    );

    always_comb begin
        an_next   = 8'hFF;
        seg_next  = 7'h7F;
        dp_next   = 1'b1;
        tick_next = frame_seen && (digit == 3'd0) && (cnt == '0);
        if (state == ON && active_en[digit]) begin
            an_next[digit] = 1'b0;
            seg_next       = ~cur_seg;
            dp_next        = ~active_dp[digit];
        end
    end

    // Output register stage
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            an_p1   <= 8'hFF;
            seg_p1  <= 7'h7F;
            dp_p1   <= 1'b1;
            tick_p1 <= 1'b0;
        end else begin
            an_p1   <= an_next;
            seg_p1  <= seg_next;
            dp_p1   <= dp_next;
            tick_p1 <= tick_next;
        end
    end

    assign AN         = an_p1;
    assign {CG, CF, CE, CD, CC, CB, CA} = seg_p1;
    assign DP         = dp_p1;
    assign FRAME_TICK = tick_p1;

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Time-multiplexes the shared cathode bus (CA..CG, DP) of the 8-digit common-anode display across AN[7:0].
- Holds a 32-bit hex value (8 nibbles), a per-digit enable mask and a per-digit decimal-point mask in shadow registers.
- Shadow registers are double-buffered so a mid-frame update never tears.
- Inserts a blanking gap before each digit to suppress ghosting; drives the existing bin_to_seven_seg decoder.

Parameters:
- DIGIT_CYCLES, 100000, clock cycles per digit slot (1 kHz/digit at 100 MHz); minimum BLANK_CYCLES+1.
- BLANK_CYCLES, 2000, cycles at the start of each slot with all anodes off; minimum 1.

Ports:
- CLK100MHZ  in  1  system clock, 100 MHz.
- CPU_RESETN  in  1  asynchronous, active-low reset.
- VAL  in  32  digit values; VAL[4k+3:4k] is digit k.
- DP_IN  in  8  decimal point per digit, 1 = lit.
- DIGIT_EN  in  8  digit enable, 1 = shown.
- UPDATE  in  1  one-cycle strobe that captures VAL/DP_IN/DIGIT_EN into the pending buffer.
- CA,CB,CC,CD,CE,CF,CG  out  1 each  segment cathodes, active-low.
- DP  out  1  decimal-point cathode, active-low.
- AN  out  8  anodes, active-low.
- FRAME_TICK  out  1  one-cycle pulse when digit 0 slot begins.

Behaviour:
- Reset (async assert, sync release):
  - cnt=0, digit=0, state=BLANK.
  - AN=8'hFF; CA..CG=1; DP=1; FRAME_TICK=0.
  - Pending and active buffers cleared to 0, so the display is dark until the first UPDATE is applied.
  - pend_valid=0.
- Slot counter:
  - cnt counts 0..DIGIT_CYCLES-1, then wraps to 0.
  - digit increments on the wrap, 7 wraps to 0.
- FSM (two states):
  - BLANK while cnt < BLANK_CYCLES.
  - ON while cnt >= BLANK_CYCLES.
  - BLANK->ON at cnt==BLANK_CYCLES.
  - ON->BLANK at wrap.
- Outputs are registered with 1-cycle latency from the (state, digit, cnt) that produced them:
  - BLANK: AN=8'hFF, all cathodes 1.
  - ON with active_en[digit]=1: AN = ~(8'b1 << digit); {CG..CA} = ~decode(active_val[digit]); DP = ~active_dp[digit].
  - ON with active_en[digit]=0: AN=8'hFF, cathodes 1. The slot still elapses, so duty cycle is constant.
- Decoder: bin_to_seven_seg gives active-high {g,f,e,d,c,b,a} for 0..F.
- Double buffering:
  - UPDATE=1 copies the inputs into the pending buffer and sets pend_valid.
  - Back-to-back UPDATEs: the last one wins.
  - Transfer point is the cycle with digit==7 and cnt==DIGIT_CYCLES-1 (the frame boundary). There, if pend_valid, active<=pending and pend_valid<=0.
  - If UPDATE coincides with the transfer cycle, the new values go to pending, pend_valid stays 1, and they apply at the next frame. The transfer uses the old pending contents.
- FRAME_TICK:
  - Registered; asserted for exactly one cycle, aligned with the first BLANK output cycle of digit 0.
  - First pulse occurs after the first full frame following reset, not at reset.
- At most one anode is ever low.
- No anode is low in the cycle on either side of a digit change (guaranteed by BLANK_CYCLES>=1).
- Reset mid-frame: outputs go dark immediately (asynchronous), and the pending UPDATE is discarded.

Decomposition:
- Package seven_seg_pkg:
  - constant NUM_DIGITS=8;
  - typedef nibble_t (logic[3:0]);
  - typedef seg_t (logic[6:0], order {g..a});
  - typedef enum scan_state_t {BLANK, ON}.
- One sub-module: bin_to_seven_seg (existing combinational decoder, reused unchanged).
- Counter, FSM and buffers all stay in seven_seg_scanner.

Test Plan (DIGIT_CYCLES=8, BLANK_CYCLES=2):
1. Reset: hold CPU_RESETN=0 for 5 cycles -> AN=8'hFF, CA..CG=1, DP=1, FRAME_TICK=0. Release, run 64 cycles with no UPDATE -> AN stays 8'hFF.
2. UPDATE pulse with VAL=32'h7654_3210, DIGIT_EN=8'hFF, DP_IN=8'h00 -> active from the next frame boundary.
   - Each slot: 2 cycles AN=8'hFF, then 6 cycles with AN low on one digit.
   - Digit 0 shows {CG..CA}=7'b1000000; digit 1 shows 7'b1111001.
   - FRAME_TICK period = 64 cycles.
3. Enable/DP masks: DIGIT_EN=8'b0000_0101, DP_IN=8'b0000_0100 -> only AN[0] and AN[2] ever go low; DP=0 only while AN[2]=0; slot timing unchanged.
4. Tear-free update: UPDATE with VAL=32'hFFFF_FFFF mid-digit-3 of a frame showing 32'h0 -> digits 3..7 of that frame still show 0; the next frame shows F on all digits ({CG..CA}=7'b0001110).
5. Simultaneous UPDATE and transfer cycle: pulse UPDATE exactly at digit 7, cnt=7 -> the previously pending value applies now; the new value applies one frame later (64 cycles).
6. Async reset mid-ON: assert CPU_RESETN low with AN=8'hFB -> AN=8'hFF in the same cycle without a clock edge. After release, the display is dark until a new UPDATE.
